// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: sample stream, pattern configuration and match outputs.
// The master side drives stream/config; the slave side (the detector) drives the results.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) ();
  logic               clear;
  logic               en;
  logic               x;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               z;
  logic               z_q;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output clear, en, x, pattern, len, overlap,
    input  z, z_q, cfg_err, match_count
  );

  modport slave (
    input  clear, en, x, pattern, len, overlap,
    output z, z_q, cfg_err, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector: Mealy z, registered z_q, overlap select.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int                FILL_W   = $clog2(MAX_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);

  logic [MAX_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_p1;
  logic               accept;
  logic               cfg_err;
  logic               match;
  logic               z_q;

  assign window  = {hist, bus.x};
  assign accept  = bus.en & ~bus.clear;
  assign fill_p1 = LEN_W'(fill) + LEN_W'(1);
  assign cfg_err = (bus.len == '0) || (bus.len > LEN_W'(MAX_LEN));

  // Only the low len bits of the window and pattern take part in the compare.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < bus.len);
    end
  end

  // Gating with reset keeps z low during reset even for len=1, where fill alone would not.
  assign match = ~reset & accept & ~cfg_err & (fill_p1 >= bus.len) &
                 (((window ^ bus.pattern) & len_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      hist <= '0;
      fill <= '0;
      z_q  <= 1'b0;
    end else begin
      z_q <= match;
      if (bus.clear) begin
        hist <= '0;
        fill <= '0;
      end else if (bus.en) begin
        hist <= window[MAX_LEN-2:0];
        // Non-overlapping mode forgets the matched bits; fill saturates so len=MAX_LEN keeps matching.
        if (match && !bus.overlap) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (bus.clear) begin
      count <= '0;
    end else if (match && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign bus.match_count = count;
`else
  assign bus.match_count = '0;
`endif

  assign bus.z       = match;
  assign bus.z_q     = z_q;
  assign bus.cfg_err = cfg_err;
endmodule
